// File: rtl/tlc_pkg.sv
// Shared definitions for the timed traffic light controller.
//   lamp_t   : 2-bit lamp drive code (RED, YELLOW, GREEN, OFF)
//   state_t  : controller phase encoding, also exported on the phase output
package tlc_pkg;

    typedef logic [1:0] lamp_t;

    localparam lamp_t RED    = 2'd0;
    localparam lamp_t YELLOW = 2'd1;
    localparam lamp_t GREEN  = 2'd2;
    localparam lamp_t OFF    = 2'd3;

    // Encoding 3'd7 is unused; the controller recovers from it through AR2.
    typedef enum logic [2:0] {
        HWY_G = 3'd0,
        HWY_Y = 3'd1,
        AR1   = 3'd2,
        CTY_G = 3'd3,
        CTY_Y = 3'd4,
        AR2   = 3'd5,
        FLASH = 3'd6
    } state_t;

endpackage

// File: rtl/timed_traffic_light_controller_if.sv
// Junction-side signal bundle of the timed traffic light controller.
//   traffic   : country-road vehicle sensor (asynchronous to clk)
//   flash_req : flashing-mode request (asynchronous to clk)
//   hwy       : highway lamp drive
//   cntry     : country-road lamp drive
//   phase     : current controller state, for monitoring
// master: sensor/mode source and lamp consumer. slave: the controller.
interface timed_traffic_light_controller_if;
    import tlc_pkg::*;

    logic       traffic;
    logic       flash_req;
    lamp_t      hwy;
    lamp_t      cntry;
    logic [2:0] phase;

    modport master (
        output traffic,
        output flash_req,
        input  hwy,
        input  cntry,
        input  phase
    );

    modport slave (
        input  traffic,
        input  flash_req,
        output hwy,
        output cntry,
        output phase
    );

endinterface

// File: rtl/tlc_sync.sv
// Multi-stage flip-flop synchroniser with synchronous active-low clear.
//   clk     : destination clock
//   clear_n : synchronous active-low clear, empties the chain
//   d_i     : asynchronous input
//   q_o     : d_i delayed by STAGES clocks
module tlc_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic clear_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sh_q;

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= {sh_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sh_q[STAGES-1];

endmodule

// File: rtl/timed_traffic_light_controller.sv
// Highway/country-road junction controller with a single phase timer.
//   clk     : clock
//   clear_n : synchronous active-low reset (forces highway green)
//   bus     : slave side of timed_traffic_light_controller_if
//             (traffic, flash_req in; hwy, cntry, phase out)
// Highway rests green; country traffic earns a green after the highway
// minimum green. Flash mode blinks highway yellow / country red.
module timed_traffic_light_controller
    import tlc_pkg::*;
#(
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned HWY_MIN_GREEN   = 8,
    parameter int unsigned CNTRY_MAX_GREEN = 6,
    parameter int unsigned YELLOW_CYC      = 3,
    parameter int unsigned ALLRED_CYC      = 2,
    parameter int unsigned FLASH_HALF      = 4,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                              clk,
    input  logic                              clear_n,
    timed_traffic_light_controller_if.slave   bus
);

    typedef logic [CNT_W-1:0] tmr_t;

    // Timer reload value (duration - 1) for the state being entered.
    function automatic tmr_t load_of(input state_t s);
        int unsigned d;
        case (s)
            HWY_G:        d = HWY_MIN_GREEN;
            HWY_Y, CTY_Y: d = YELLOW_CYC;
            CTY_G:        d = CNTRY_MAX_GREEN;
            FLASH:        d = FLASH_HALF;
            default:      d = ALLRED_CYC;
        endcase
        return tmr_t'(d - 1);
    endfunction

    // Lamp pair {hwy, cntry} shown in a given state.
    function automatic logic [3:0] lamps_of(input state_t s, input logic b);
        case (s)
            HWY_G:   return {GREEN, RED};
            HWY_Y:   return {YELLOW, RED};
            CTY_G:   return {RED, GREEN};
            CTY_Y:   return {RED, YELLOW};
            FLASH:   return b ? {YELLOW, RED} : {OFF, OFF};
            default: return {RED, RED};
        endcase
    endfunction

    logic   traffic_s;
    logic   flash_s;
    state_t state_q, state_d;
    tmr_t   tmr_q, tmr_d;
    logic   tmr_exp;
    logic   blink_q, blink_d;
    lamp_t  hwy_q, hwy_d;
    lamp_t  cntry_q, cntry_d;

    tlc_sync #(.STAGES(SYNC_STAGES)) u_sync_traffic (
        .clk     (clk),
        .clear_n (clear_n),
        .d_i     (bus.traffic),
        .q_o     (traffic_s)
    );

    tlc_sync #(.STAGES(SYNC_STAGES)) u_sync_flash (
        .clk     (clk),
        .clear_n (clear_n),
        .d_i     (bus.flash_req),
        .q_o     (flash_s)
    );

    always_comb begin
        state_d = state_q;
        blink_d = blink_q;
        tmr_exp = (tmr_q == '0);
        tmr_d   = tmr_exp ? tmr_q : tmr_q - tmr_t'(1);

        case (state_q)
            HWY_G: if (tmr_exp && (traffic_s || flash_s)) state_d = HWY_Y;
            HWY_Y: if (tmr_exp) state_d = AR1;
            AR1:   if (tmr_exp) state_d = flash_s ? FLASH : CTY_G;
            // Gap-out can fire on the very first country-green cycle.
            CTY_G: if (!traffic_s || tmr_exp || flash_s) state_d = CTY_Y;
            CTY_Y: if (tmr_exp) state_d = AR2;
            AR2:   if (tmr_exp) state_d = flash_s ? FLASH : HWY_G;
            FLASH: begin
                if (!flash_s) begin
                    state_d = AR2;
                end else if (tmr_exp) begin
                    blink_d = ~blink_q;
                    tmr_d   = load_of(FLASH);
                end
            end
            default: state_d = AR2;
        endcase

        if (state_d != state_q) begin
            tmr_d = load_of(state_d);
            if (state_d == FLASH) blink_d = 1'b1;
        end

        // Lamps decode the next state so they register on the same edge.
        {hwy_d, cntry_d} = lamps_of(state_d, blink_d);
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q <= HWY_G;
            tmr_q   <= load_of(HWY_G);
            blink_q <= 1'b0;
            hwy_q   <= GREEN;
            cntry_q <= RED;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            blink_q <= blink_d;
            hwy_q   <= hwy_d;
            cntry_q <= cntry_d;
        end
    end

    assign bus.hwy   = hwy_q;
    assign bus.cntry = cntry_q;
    assign bus.phase = state_q;

endmodule

// File: tb/tb_timed_traffic_light_controller.sv
// Self-checking bench for timed_traffic_light_controller: directed
// scenarios plus randomized sensor/flash/reset stimulus against a
// cycle-count reference model of the junction rules.
module tb_timed_traffic_light_controller;

    localparam int CNT_W = 8;
    localparam int HMG   = 8;
    localparam int CMG   = 6;
    localparam int YEL   = 3;
    localparam int AR    = 2;
    localparam int FH    = 4;
    localparam int SYNC  = 2;

    localparam logic [1:0] L_RED = 2'd0;
    localparam logic [1:0] L_YEL = 2'd1;
    localparam logic [1:0] L_GRN = 2'd2;
    localparam logic [1:0] L_OFF = 2'd3;

    localparam int P_HG  = 0;
    localparam int P_HY  = 1;
    localparam int P_AR1 = 2;
    localparam int P_CG  = 3;
    localparam int P_CY  = 4;
    localparam int P_AR2 = 5;
    localparam int P_FL  = 6;

    logic clk     = 1'b0;
    logic clear_n = 1'b0;

    timed_traffic_light_controller_if bus();

    timed_traffic_light_controller #(
        .CNT_W           (CNT_W),
        .HWY_MIN_GREEN   (HMG),
        .CNTRY_MAX_GREEN (CMG),
        .YELLOW_CYC      (YEL),
        .ALLRED_CYC      (AR),
        .FLASH_HALF      (FH),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: phase, cycles spent so far in it (1 on entry),
    // blink level, and input history standing in for the synchronisers.
    int m_ph       = 0;
    int m_el       = 1;
    bit m_blink    = 1'b0;
    bit m_valid    = 1'b0;
    bit m_rst_edge = 1'b0;
    bit th[$];
    bit fh[$];

    function automatic int dur(input int ph);
        case (ph)
            P_HG:       return HMG;
            P_HY, P_CY: return YEL;
            P_CG:       return CMG;
            P_FL:       return FH;
            default:    return AR;
        endcase
    endfunction

    function automatic logic [3:0] lamps(input int ph, input bit b);
        case (ph)
            P_HG:    return {L_GRN, L_RED};
            P_HY:    return {L_YEL, L_RED};
            P_CG:    return {L_RED, L_GRN};
            P_CY:    return {L_RED, L_YEL};
            P_FL:    return b ? {L_YEL, L_RED} : {L_OFF, L_OFF};
            default: return {L_RED, L_RED};
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit ts, fs, ex;
        int nx;
        if (!clear_n) begin
            m_ph = P_HG; m_el = 1; m_blink = 1'b0;
            th.delete(); fh.delete();
            for (int i = 0; i < SYNC; i++) begin
                th.push_back(1'b0); fh.push_back(1'b0);
            end
            m_valid = 1'b1; m_rst_edge = 1'b1;
        end else if (m_valid) begin
            m_rst_edge = 1'b0;
            ts = th.pop_front(); fs = fh.pop_front();
            th.push_back(bus.traffic); fh.push_back(bus.flash_req);
            ex = (m_el >= dur(m_ph));
            nx = m_ph;
            case (m_ph)
                P_HG:    if (ex && (ts || fs)) nx = P_HY;
                P_HY:    if (ex) nx = P_AR1;
                P_AR1:   if (ex) nx = fs ? P_FL : P_CG;
                P_CG:    if (!ts || ex || fs) nx = P_CY;
                P_CY:    if (ex) nx = P_AR2;
                P_AR2:   if (ex) nx = fs ? P_FL : P_HG;
                default: if (!fs) nx = P_AR2;
            endcase
            if (nx != m_ph) begin
                m_ph = nx; m_el = 1;
                if (nx == P_FL) m_blink = 1'b1;
            end else if (m_ph == P_FL && ex) begin
                m_blink = !m_blink; m_el = 1;
            end else begin
                m_el++;
            end
        end
    end

    logic [1:0] prev_h  = L_GRN;
    logic [1:0] prev_c  = L_RED;
    int         prev_ph = 0;

    always @(negedge clk) begin : monitor
        logic [3:0] e;
        if (m_valid) begin
            e = lamps(m_ph, m_blink);
            tests++;
            if (bus.hwy !== e[3:2] || bus.cntry !== e[1:0] || bus.phase !== 3'(m_ph)) begin
                fails++;
                $display("FAIL model t=%0t got hwy=%0d cntry=%0d phase=%0d required hwy=%0d cntry=%0d phase=%0d",
                         $time, bus.hwy, bus.cntry, bus.phase, e[3:2], e[1:0], m_ph);
            end
            tests++;
            if (bus.hwy !== L_RED && bus.cntry !== L_RED && !(bus.hwy === L_OFF && bus.cntry === L_OFF)) begin
                fails++;
                $display("FAIL safety t=%0t got hwy=%0d cntry=%0d required at least one RED",
                         $time, bus.hwy, bus.cntry);
            end
            if ((bus.hwy === L_GRN && prev_h !== L_GRN) || (bus.cntry === L_GRN && prev_c !== L_GRN)) begin
                tests++;
                if (!(m_rst_edge || prev_ph == P_AR1 || prev_ph == P_AR2)) begin
                    fails++;
                    $display("FAIL green_entry t=%0t got previous phase=%0d required 2, 5 or reset",
                             $time, prev_ph);
                end
            end
            prev_h  = bus.hwy;
            prev_c  = bus.cntry;
            prev_ph = int'(bus.phase);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input bit t, input bit f);
        bus.traffic = t; bus.flash_req = f;
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
    endtask

    task automatic measure(input int ph, output int n);
        n = 0;
        while (bus.phase === 3'(ph) && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_phase(input int ph, output bit ok);
        int k;
        k = 0;
        while (bus.phase !== 3'(ph) && k < 200) begin
            k++;
            tick();
        end
        ok = (bus.phase === 3'(ph));
    endtask

    task automatic test_reset();
        bus.traffic = 1'b0; bus.flash_req = 1'b0; clear_n = 1'b0;
        tick(); tick();
        tests++;
        if (bus.hwy !== L_GRN || bus.cntry !== L_RED || bus.phase !== 3'd0) begin
            fails++;
            $display("FAIL reset_state got hwy=%0d cntry=%0d phase=%0d required 2/0/0", bus.hwy, bus.cntry, bus.phase);
        end
        tests++;
        if (dut.tmr_q !== CNT_W'(HMG - 1)) begin
            fails++;
            $display("FAIL reset_tmr got %0d required %0d", dut.tmr_q, HMG - 1);
        end
        clear_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            tests++;
            if (bus.hwy !== L_GRN || bus.cntry !== L_RED || bus.phase !== 3'd0) begin
                fails++;
                $display("FAIL idle_hold cycle=%0d got hwy=%0d cntry=%0d phase=%0d required 2/0/0",
                         i, bus.hwy, bus.cntry, bus.phase);
            end
        end
    endtask

    task automatic test_max_out();
        int exp_len[6];
        int n;
        exp_len = '{HMG, YEL, AR, CMG, YEL, AR};
        do_reset(1'b1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tests++;
            if (bus.phase !== 3'(k % 6)) begin
                fails++;
                $display("FAIL maxout_order step=%0d got phase=%0d required %0d", k, bus.phase, k % 6);
            end
            measure(k % 6, n);
            tests++;
            if (n != exp_len[k % 6]) begin
                fails++;
                $display("FAIL maxout_len step=%0d got %0d cycles required %0d", k, n, exp_len[k % 6]);
            end
        end
    endtask

    task automatic test_gap_out();
        bit ok;
        int n;
        do_reset(1'b1, 1'b0);
        wait_phase(P_CG, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL gap_reach got phase=%0d required 3", bus.phase);
        end
        tick();
        bus.traffic = 1'b0;
        measure(P_CG, n);
        n += 1;
        tests++;
        if (n != 2 + SYNC) begin
            fails++;
            $display("FAIL gap_len got %0d cycles required %0d", n, 2 + SYNC);
        end
        measure(P_CY, n);
        tests++;
        if (n != YEL) begin
            fails++;
            $display("FAIL gap_yellow got %0d cycles required %0d", n, YEL);
        end
        measure(P_AR2, n);
        tests++;
        if (n != AR) begin
            fails++;
            $display("FAIL gap_allred got %0d cycles required %0d", n, AR);
        end
        measure(P_HG, n);
        tests++;
        if (n != 200) begin
            fails++;
            $display("FAIL gap_rest got %0d green cycles required 200", n);
        end
    endtask

    task automatic test_flash();
        int n;
        bit on;
        do_reset(1'b0, 1'b0);
        tick(); tick();
        bus.flash_req = 1'b1;
        measure(P_HG, n);
        tests++;
        if (n != HMG - 2) begin
            fails++;
            $display("FAIL flash_hg got %0d cycles required %0d", n, HMG - 2);
        end
        measure(P_HY, n);
        tests++;
        if (n != YEL) begin
            fails++;
            $display("FAIL flash_yellow got %0d cycles required %0d", n, YEL);
        end
        measure(P_AR1, n);
        tests++;
        if (n != AR) begin
            fails++;
            $display("FAIL flash_ar1 got %0d cycles required %0d", n, AR);
        end
        for (int i = 0; i < 16; i++) begin
            on = (((i / FH) % 2) == 0);
            tests++;
            if (bus.phase !== 3'd6 || bus.hwy !== (on ? L_YEL : L_OFF) || bus.cntry !== (on ? L_RED : L_OFF)) begin
                fails++;
                $display("FAIL flash_blink cycle=%0d got phase=%0d hwy=%0d cntry=%0d required 6/%0d/%0d",
                         i, bus.phase, bus.hwy, bus.cntry, on ? L_YEL : L_OFF, on ? L_RED : L_OFF);
            end
            tick();
        end
        bus.flash_req = 1'b0;
        bus.traffic   = 1'b1;
        measure(P_FL, n);
        tests++;
        if (bus.phase !== 3'd5) begin
            fails++;
            $display("FAIL flash_exit got phase=%0d required 5", bus.phase);
        end
        measure(P_AR2, n);
        tests++;
        if (n != AR) begin
            fails++;
            $display("FAIL flash_ar2 got %0d cycles required %0d", n, AR);
        end
        measure(P_HG, n);
        tests++;
        if (n != HMG) begin
            fails++;
            $display("FAIL flash_min_green got %0d cycles required %0d", n, HMG);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        do_reset(1'b1, 1'b0);
        wait_phase(P_CG, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL mid_reach got phase=%0d required 3", bus.phase);
        end
        tick();
        clear_n = 1'b0;
        tick();
        tests++;
        if (bus.hwy !== L_GRN || bus.cntry !== L_RED || bus.phase !== 3'd0) begin
            fails++;
            $display("FAIL mid_reset got hwy=%0d cntry=%0d phase=%0d required 2/0/0", bus.hwy, bus.cntry, bus.phase);
        end
        tests++;
        if (dut.tmr_q !== CNT_W'(HMG - 1)) begin
            fails++;
            $display("FAIL mid_tmr got %0d required %0d", dut.tmr_q, HMG - 1);
        end
        clear_n = 1'b1;
        measure(P_HG, n);
        tests++;
        if (n != HMG) begin
            fails++;
            $display("FAIL mid_green got %0d cycles required %0d", n, HMG);
        end
    endtask

    task automatic test_random();
        int hold_t = 0;
        int hold_f = 0;
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if (hold_t == 0) begin
                bus.traffic = ($urandom_range(0, 1) == 1);
                hold_t = int'($urandom_range(1, 20));
            end else begin
                hold_t--;
            end
            if (hold_f == 0) begin
                bus.flash_req = ($urandom_range(0, 7) == 0);
                hold_f = int'($urandom_range(1, 60));
            end else begin
                hold_f--;
            end
            clear_n = ($urandom_range(0, 399) != 0);
            tick();
            tests++;
            if ($isunknown(bus.phase) || bus.phase === 3'd7) begin
                fails++;
                $display("FAIL rand_phase cycle=%0d got phase=%0d required 0..6", i, bus.phase);
            end
        end
        clear_n = 1'b1;
    endtask

    initial begin
        bus.traffic   = 1'b0;
        bus.flash_req = 1'b0;
        test_reset();
        test_max_out();
        test_gap_out();
        test_flash();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timed_traffic_light_controller.md
Name: timed_traffic_light_controller

Overview:
Parametrised highway/country-road junction controller. It is the successor to the untimed sensor-driven controller and adds:
- a synchronised country-road sensor input
- programmable minimum-green, maximum-green, yellow and all-red durations from one phase timer
- a night/fault flashing mode
Sits between the road sensor/mode inputs and the lamp drivers; one instance per junction.

Parameters:
CNT_W, 8, phase timer width; every duration below must be ≥1 and ≤2^CNT_W.
HWY_MIN_GREEN, 8, cycles highway stays green before it may yield.
CNTRY_MAX_GREEN, 6, cycles country green is held at most while traffic persists.
YELLOW_CYC, 3, yellow duration for either road.
ALLRED_CYC, 2, all-red clearance duration.
FLASH_HALF, 4, cycles per on/off half-period in flash mode.
SYNC_STAGES, 2, flip-flop stages on traffic and flash_req (≥2).

Ports:
clk  input  1  clock
clear_n  input  1  synchronous, active-low reset
traffic  input  1  country-road vehicle sensor, asynchronous
flash_req  input  1  request flashing mode, asynchronous
hwy  output  2  highway lamp: RED=0, YELLOW=1, GREEN=2, OFF=3
cntry  output  2  country lamp, same encoding
phase  output  3  current state encoding, for debug/monitor

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clear_n sampled on rising clk).
  - State values while clear_n=0:
    - state=HWY_G, tmr=HWY_MIN_GREEN-1, blink=0, blink counter=0, synchronisers cleared
    - hwy=GREEN, cntry=RED, phase=0
  - Reset mid-phase aborts immediately to these values.
- Synchronisers: traffic_s and flash_s are the inputs delayed by SYNC_STAGES cycles. The FSM uses only the synchronised versions.
- State encoding:
  - HWY_G=0, HWY_Y=1, AR1=2, CTY_G=3, CTY_Y=4, AR2=5, FLASH=6; 7 is illegal and goes to AR2 on next clk.
- Outputs are a registered decode of next state, so lamps and phase change on the same edge as state.
  - HWY_G: G/R. HWY_Y: Y/R. AR1, AR2: R/R. CTY_G: R/G. CTY_Y: R/Y.
  - FLASH: hwy=YELLOW/OFF and cntry=RED/OFF, both following blink.
- Timer:
  - On every state entry, tmr loads D-1, where D is that state's duration. FLASH loads FLASH_HALF-1.
  - Each cycle in state, tmr decrements and saturates at 0.
  - exp = (tmr==0).
- Transitions, evaluated every cycle:
  - HWY_G: exp && (traffic_s || flash_s) → HWY_Y; otherwise hold (green extends indefinitely).
  - HWY_Y: exp → AR1.
  - AR1: exp && flash_s → FLASH; exp && !flash_s → CTY_G.
  - CTY_G: !traffic_s (gap-out, any cycle including the first) or exp (max-out) or flash_s → CTY_Y.
  - CTY_Y: exp → AR2.
  - AR2: exp && flash_s → FLASH; exp → HWY_G.
  - FLASH: !flash_s → AR2 (full ALLRED_CYC clearance), then HWY_G.
    - While in FLASH, each exp toggles blink and reloads tmr.
    - blink starts at 1 (lamps on) on entry.
- Simultaneous events:
  - flash_s has priority over traffic_s only at the AR1 and AR2 exits.
  - A yellow is never skipped or shortened by any input.
  - An all-red always precedes any green.
- Safety invariant: hwy and cntry are never both non-RED, except the FLASH/OFF combinations.
- Duration D=1 means the state lasts exactly one cycle.

Decomposition:
- Shared package tlc_pkg:
  - lamp encoding constants RED/YELLOW/GREEN/OFF
  - state encoding constants
  - a lamp_t 2-bit type
- One sub-module: tlc_sync, a parametrised SYNC_STAGES synchroniser with synchronous active-low clear. It is instantiated twice.
- Timer, FSM and output decode stay in the top module.

Test Plan:
- Reset, then traffic=0 for 50 cycles → hwy=GREEN, cntry=RED throughout; phase=0.
- traffic=1 held from reset release (defaults) → HWY_G 8 cycles, HWY_Y 3, AR1 2, CTY_G 6 (max-out), CTY_Y 3, AR2 2, then HWY_G; full loop 24 cycles. The loop repeats while traffic stays high.
- traffic pulse rises, then drops 2 cycles after CTY_G entry → CTY_G lasts 4 cycles: the 2-cycle hold plus SYNC_STAGES=2 of synchroniser latency. Then CTY_Y for the full 3 cycles.
- flash_req=1 asserted during HWY_G with traffic=0 → HWY_Y (3), AR1 (2), FLASH.
  - hwy toggles YELLOW/OFF and cntry RED/OFF every 4 cycles, both starting on.
  - Deassert flash_req → AR2 for 2 cycles, then HWY_G with a full 8-cycle min-green.
- clear_n=0 for one cycle while in CTY_G → next edge gives hwy=GREEN, cntry=RED, phase=0, tmr=7.
- Every scenario asserts the safety invariant each cycle and that no green follows anything other than AR1, AR2 or reset.
